// File: rtl/xoro_pkg.sv
// Shared definitions for the buffered UART transmitter: register offsets,
// STATUS bit positions and the serialiser state encoding.
package xoro_pkg;

  // Register offsets, decoded from mem_addr[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CONFIG = 2'd2;

  // STATUS register layout
  localparam int ST_FULL_BIT  = 0;
  localparam int ST_EMPTY_BIT = 1;
  localparam int ST_BUSY_BIT  = 2;
  localparam int ST_LEVEL_LSB = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// picorv32 native memory bus slice seen by one peripheral, including its
// address-decoder chip select. The slave drives mem_ready/mem_rdata only
// while enable is high.
interface uart_tx_fifo_if;
  logic        enable;
  logic        mem_valid;
  logic        mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A push while full is taken only
// when the same cycle also pops, so the caller can stall on !(~full | pop).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rptr];
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^AW)
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter on the picorv32 native bus. Bytes written to
// TXDATA queue in a FIFO and are serialised 8N1 at a programmable divisor.
// Optional parity bit: define UART_TX_PARITY_EN.
module uart_tx_fifo
  import xoro_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int DIV_W     = 16,
  parameter int DIV_RESET = 868
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_fifo_if.slave bus,
  output logic          serial_out,
  output logic          tx_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tx_state_t        state;
  logic [DIV_W-1:0] div_q, d_cur, bit_len, baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       tx_byte;
  logic             ready_q;
  logic [31:0]      rdata_q, rd_mux;
  logic             req, is_wr, push_req, push_ok, ack;
  logic [1:0]       sel;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [7:0]       fifo_rdata;
  logic [AW:0]      fifo_level;
`ifdef UART_TX_PARITY_EN
  logic             par_en_q, par_odd_q, frm_par_en, frm_par_odd;
`endif

  // A request is new only while we are not already acking the previous one
  assign req      = bus.enable && bus.mem_valid && !ready_q;
  assign sel      = bus.mem_addr[3:2];
  assign is_wr    = |bus.mem_wstrb;
  assign push_req = req && is_wr && (sel == REG_TXDATA) && bus.mem_wstrb[0];
  assign fifo_pop = !fifo_empty &&
                    ((state == ST_IDLE) || ((state == ST_STOP) && (baud_cnt == '0)));
  assign push_ok  = !fifo_full || fifo_pop;
  // Full-FIFO writes stall without ack until a pop frees a slot
  assign ack      = req && !(push_req && !push_ok);
  assign d_cur    = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;
  assign tx_empty = fifo_empty && (state == ST_IDLE);

  logic unused_bus;
  assign unused_bus = ^{bus.mem_instr, bus.mem_addr[31:4], bus.mem_addr[1:0],
                        bus.mem_wdata[31:DIV_W]};

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .wdata (bus.mem_wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Read data mux for STATUS/CONFIG; other offsets read zero
  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_STATUS: begin
        rd_mux[ST_FULL_BIT]          = fifo_full;
        rd_mux[ST_EMPTY_BIT]         = fifo_empty;
        rd_mux[ST_BUSY_BIT]          = (state != ST_IDLE);
        rd_mux[ST_LEVEL_LSB +: 8]    = 8'(fifo_level);
      end
      REG_CONFIG: begin
        rd_mux[DIV_W-1:0] = div_q;
`ifdef UART_TX_PARITY_EN
        rd_mux[16] = par_en_q;
        rd_mux[17] = par_odd_q;
`endif
      end
      default: rd_mux = '0;
    endcase
  end

  // Bus ack, registered read data and CONFIG register
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      div_q   <= DIV_W'(DIV_RESET);
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
`endif
    end else begin
      ready_q <= ack;
      rdata_q <= (ack && !is_wr) ? rd_mux : '0;
      if (ack && is_wr && (sel == REG_CONFIG)) begin
        div_q <= bus.mem_wdata[DIV_W-1:0];
`ifdef UART_TX_PARITY_EN
        par_en_q  <= bus.mem_wdata[16];
        par_odd_q <= bus.mem_wdata[17];
`endif
      end
    end
  end

  assign bus.mem_ready = bus.enable ? ready_q : 1'bz;
  assign bus.mem_rdata = bus.enable ? rdata_q : 32'bz;

  // Serialiser: bit time and parity mode are latched when a frame starts
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      serial_out <= 1'b1;
      baud_cnt   <= '0;
      bit_len    <= DIV_W'(2);
      bit_idx    <= '0;
      tx_byte    <= '0;
`ifdef UART_TX_PARITY_EN
      frm_par_en  <= 1'b0;
      frm_par_odd <= 1'b0;
`endif
    end else if (fifo_pop) begin
      state      <= ST_START;
      serial_out <= 1'b0;
      tx_byte    <= fifo_rdata;
      bit_len    <= d_cur;
      baud_cnt   <= d_cur - 1'b1;
`ifdef UART_TX_PARITY_EN
      frm_par_en  <= par_en_q;
      frm_par_odd <= par_odd_q;
`endif
    end else if ((state != ST_IDLE) && (baud_cnt != '0)) begin
      baud_cnt <= baud_cnt - 1'b1;
    end else begin
      baud_cnt <= bit_len - 1'b1;
      case (state)
        ST_START: begin
          state      <= ST_DATA;
          bit_idx    <= '0;
          serial_out <= tx_byte[0];
        end
        ST_DATA: begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            if (frm_par_en) begin
              state      <= ST_PARITY;
              serial_out <= (^tx_byte) ^ frm_par_odd;
            end else begin
              state      <= ST_STOP;
              serial_out <= 1'b1;
            end
`else
            state      <= ST_STOP;
            serial_out <= 1'b1;
`endif
          end else begin
            bit_idx    <= bit_idx + 3'd1;
            serial_out <= tx_byte[bit_idx + 3'd1];
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          state      <= ST_STOP;
          serial_out <= 1'b1;
        end
`endif
        default: begin
          state      <= ST_IDLE;
          serial_out <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed + randomized bench for uart_tx_fifo (DEPTH=4). The line is
// recorded one sample per clock and decoded against a queue of expected
// bytes, each with the bit time and parity mode it should be sent with.
module tb_uart_tx_fifo;
  import xoro_pkg::*;

  localparam int DEPTH     = 4;
  localparam int DIV_RESET = 868;
`ifdef UART_TX_PARITY_EN
  localparam logic [31:0] CFG4 = 32'h0000_0004;
`else
  localparam logic [31:0] CFG4 = 32'h0003_0004;
`endif

  logic clk = 1'b0;
  logic reset;
  logic serial_out, tx_empty;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .DIV_W(16), .DIV_RESET(DIV_RESET)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .serial_out (serial_out),
    .tx_empty   (tx_empty)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  bit         rec      = 1'b0;
  int         ack_idx;
  logic       line_q[$];
  logic [7:0] exp_b[$];
  int         exp_d[$];
  bit         exp_pe[$];
  bit         exp_po[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rec) line_q.push_back(serial_out);
  endtask

  task automatic xfer(input logic [1:0] r, input bit wr, input logic [31:0] wd,
                      output logic [31:0] rd, output int lat);
    bus.mem_addr  = {28'd0, r, 2'b00};
    bus.mem_wstrb = wr ? 4'hF : 4'h0;
    bus.mem_wdata = wd;
    bus.mem_valid = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (bus.mem_ready !== 1'b1 && lat < 400);
    chk("bus_ack", 32'(bus.mem_ready), 32'd1);
    ack_idx = line_q.size() - 1;
    rd = bus.mem_rdata;
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    tick();
    chk("ready_low_between", 32'(bus.mem_ready), 32'd0);
    chk("rdata_zero_between", bus.mem_rdata, 32'd0);
  endtask

  task automatic wr_reg(input logic [1:0] r, input logic [31:0] wd);
    logic [31:0] rd;
    int lat;
    xfer(r, 1'b1, wd, rd, lat);
    chk("wr_lat", 32'(lat), 32'd1);
  endtask

  task automatic rd_reg(input string tag, input logic [1:0] r, input logic [31:0] exp);
    logic [31:0] rd;
    int lat;
    xfer(r, 1'b0, 32'd0, rd, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk(tag, rd, exp);
  endtask

  // Push a byte that must be accepted at latency 1 and expect it on the line
  task automatic send(input logic [7:0] b, input int d, input bit pe, input bit po);
    wr_reg(REG_TXDATA, {24'd0, b});
    exp_b.push_back(b);
    exp_d.push_back(d);
    exp_pe.push_back(pe);
    exp_po.push_back(po);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (tx_empty !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk("tx_empty_after_drain", 32'(tx_empty), 32'd1);
    repeat (3) tick();
  endtask

  // Decode the recorded line frame by frame against the expected queue
  task automatic check_line(input string tag);
    int   i, nb, d, extra;
    logic [7:0] b;
    logic fb [0:10];
    bit   ok, pe, po;
    i = 0;
    extra = 0;
    while (i < line_q.size()) begin
      if (line_q[i] !== 1'b0) begin
        i++;
        continue;
      end
      if (exp_b.size() == 0) begin
        extra++;
        break;
      end
      b  = exp_b.pop_front();
      d  = exp_d.pop_front();
      pe = exp_pe.pop_front();
      po = exp_po.pop_front();
      fb[0] = 1'b0;
      for (int k = 0; k < 8; k++) fb[k+1] = b[k];
      fb[10] = 1'b1;
      if (pe) begin
        fb[9] = (^b) ^ po;
        nb = 11;
      end else begin
        fb[9] = 1'b1;
        nb = 10;
      end
      ok = 1'b1;
      for (int k = 0; k < nb * d; k++)
        if (i + k >= line_q.size() || line_q[i+k] !== fb[k/d]) ok = 1'b0;
      chk({tag, "_frame"}, {31'd0, ok}, 32'd1);
      i += nb * d;
    end
    chk({tag, "_extra_frames"}, 32'(extra), 32'd0);
    chk({tag, "_missing_frames"}, 32'(exp_b.size()), 32'd0);
    exp_b.delete();
    exp_d.delete();
    exp_pe.delete();
    exp_po.delete();
    line_q.delete();
  endtask

  function automatic int first_low();
    for (int k = 0; k < line_q.size(); k++)
      if (line_q[k] === 1'b0) return k;
    return -1;
  endfunction

  initial begin
    logic [31:0] rd, cfgw, exp_rb;
    int lat, s1, lows, hi, div, d, n;
    logic [1:0] pb;
    bit pe, po;

    bus.enable    = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_instr = 1'b0;
    bus.mem_wstrb = 4'h0;
    bus.mem_wdata = 32'd0;
    bus.mem_addr  = 32'd0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_serial_out", 32'(serial_out), 32'd1);
    chk("rst_tx_empty", 32'(tx_empty), 32'd1);
    chk("rst_ready", 32'(bus.mem_ready), 32'd0);
    chk("rst_rdata", bus.mem_rdata, 32'd0);
    rd_reg("rst_status", REG_STATUS, 32'h0000_0002);
    rd_reg("rst_config", REG_CONFIG, 32'(DIV_RESET));
    rd_reg("reg3_reads_zero", 2'd3, 32'd0);

    // Divisor 4; upper config bits ignored without parity support
    wr_reg(REG_CONFIG, CFG4);
    rd_reg("config_4", REG_CONFIG, 32'd4);

    // Single 0x55 frame
    rec = 1'b1;
    send(8'h55, 4, 1'b0, 1'b0);
    wait_idle(100);
    rec = 1'b0;
    check_line("byte55");

    // Overfill: first DEPTH+1 accepted at once (one pops immediately), the
    // next stalls until frame 2 starts
    rec = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      xfer(REG_TXDATA, 1'b1, {24'd0, b}, rd, lat);
      if (i < DEPTH + 1) begin
        chk("burst_lat", 32'(lat), 32'd1);
      end else begin
        s1 = first_low();
        chk("stall_withheld", 32'(lat > 1), 32'd1);
        chk("stall_ack_at_pop", 32'(ack_idx), 32'(s1 + 10 * 4));
      end
      exp_b.push_back(b);
      exp_d.push_back(4);
      exp_pe.push_back(1'b0);
      exp_po.push_back(1'b0);
    end
    wait_idle(600);
    rec = 1'b0;
    check_line("burst");

    // STATUS mid-transmission after the first pop
    rec = 1'b1;
    send(8'hA1, 4, 1'b0, 1'b0);
    send(8'hB2, 4, 1'b0, 1'b0);
    send(8'hC3, 4, 1'b0, 1'b0);
    rd_reg("status_level2_busy", REG_STATUS, 32'h0000_0204);
    wait_idle(300);
    rec = 1'b0;
    check_line("three");

    // CONFIG change mid-frame only affects the following frame
    rec = 1'b1;
    send(8'h3C, 4, 1'b0, 1'b0);
    send(8'hE7, 3, 1'b0, 1'b0);
    wr_reg(REG_CONFIG, 32'd3);
    wait_idle(300);
    rec = 1'b0;
    check_line("div_change");
    wr_reg(REG_CONFIG, CFG4);

    // Reset during data bit 3 of a 0x00 frame, another byte queued
    rec = 1'b1;
    wr_reg(REG_TXDATA, 32'h00);
    wr_reg(REG_TXDATA, 32'hFF);
    s1 = first_low();
    while (line_q.size() - 1 < s1 + 4 * 4 + 1) tick();
    chk("bit3_low_before_reset", 32'(serial_out), 32'd0);
    reset = 1'b1;
    tick();
    chk("reset_line_high", 32'(serial_out), 32'd1);
    reset = 1'b0;
    lows = 0;
    repeat (60) begin
      tick();
      if (serial_out !== 1'b1) lows++;
    end
    chk("queue_discarded", 32'(lows), 32'd0);
    chk("reset_tx_empty", 32'(tx_empty), 32'd1);
    rec = 1'b0;
    line_q.delete();
    rd_reg("status_after_reset", REG_STATUS, 32'h0000_0002);
    rd_reg("config_after_reset", REG_CONFIG, 32'(DIV_RESET));
    wr_reg(REG_CONFIG, CFG4);

    // Deselected: no ack, no push
    bus.enable    = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_wstrb = 4'hF;
    bus.mem_wdata = 32'hAA;
    bus.mem_valid = 1'b1;
    hi = 0;
    repeat (4) begin
      tick();
      if (bus.mem_ready === 1'b1) hi++;
    end
    chk("deselected_no_ready", 32'(hi), 32'd0);
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    tick();
    bus.enable = 1'b1;
    tick();
    chk("deselected_no_push", 32'(tx_empty), 32'd1);
    rd_reg("deselected_status", REG_STATUS, 32'h0000_0002);

`ifdef UART_TX_PARITY_EN
    wr_reg(REG_CONFIG, 32'h0001_0003);
    rd_reg("config_par_even", REG_CONFIG, 32'h0001_0003);
    rec = 1'b1;
    send(8'h07, 3, 1'b1, 1'b0);
    wait_idle(100);
    rec = 1'b0;
    check_line("parity_even");
    wr_reg(REG_CONFIG, 32'h0003_0004);
    rd_reg("config_par_odd", REG_CONFIG, 32'h0003_0004);
    rec = 1'b1;
    send(8'h07, 4, 1'b1, 1'b1);
    wait_idle(100);
    rec = 1'b0;
    check_line("parity_odd");
`else
    wr_reg(REG_CONFIG, 32'h0003_0004);
    rd_reg("config_par_bits_zero", REG_CONFIG, 32'h0000_0004);
    rec = 1'b1;
    send(8'h07, 4, 1'b0, 1'b0);
    wait_idle(100);
    rec = 1'b0;
    check_line("no_parity");
`endif

    // Randomized rounds: divisor, parity bits, byte count and gaps
    for (int r = 0; r < 4; r++) begin
      div  = $urandom_range(0, 6);
      pb   = 2'($urandom_range(0, 3));
      cfgw = {14'd0, pb, 16'(div)};
`ifdef UART_TX_PARITY_EN
      exp_rb = cfgw;
      pe = pb[0];
      po = pb[1];
`else
      exp_rb = cfgw & 32'h0000_FFFF;
      pe = 1'b0;
      po = 1'b0;
`endif
      wr_reg(REG_CONFIG, cfgw);
      rd_reg("rand_config", REG_CONFIG, exp_rb);
      d = (div < 2) ? 2 : div;
      n = $urandom_range(1, DEPTH + 1);
      rec = 1'b1;
      for (int i = 0; i < n; i++) begin
        send(8'($urandom), d, pe, po);
        repeat ($urandom_range(0, 2)) tick();
      end
      wait_idle(n * 11 * 6 + 100);
      rec = 1'b0;
      check_line("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
